// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_pkg
// Description : Shared constants and types for the trap sequencer:
//               RISC-V exception cause codes, the idle code, FSM state
//               encoding, event-class encoding and the ecall cause helper.
// Revision    : 1.0  initial release
// ============================================================================
package trap_pkg;

    // XLEN width encodings; data/address width W = 1 << (XLEN + 4)
    localparam int XLEN_32B = 1;
    localparam int XLEN_64B = 2;

    // Commit-code value meaning "no trap of this class this cycle"
    localparam logic [3:0] EXC_NONE = 4'hF;

    // RISC-V synchronous exception causes (mcause[3:0])
    localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_INST_ACCESS    = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INST   = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_ACCESS    = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_ACCESS   = 4'd7;
    localparam logic [3:0] EXC_ECALL_U        = 4'd8;
    localparam logic [3:0] EXC_ECALL_S        = 4'd9;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    // Privilege modes
    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    // Event class; ecall is an F/D-class trap since it commits on the f_d record
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_FD   = 2'd1,
        EV_EM   = 2'd2,
        EV_MRET = 2'd3
    } ev_class_t;

    // Ecall cause depends on the mode the ecall was executed from.
    // The reserved mode 2 is treated as M.
    function automatic logic [3:0] ecall_cause(input logic [1:0] priv);
        logic [3:0] cause;
        case (priv)
            PRIV_U:  cause = EXC_ECALL_U;
            PRIV_S:  cause = EXC_ECALL_S;
            default: cause = EXC_ECALL_M;
        endcase
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer_if
// Description : Bundle of pipeline event inputs, CSR values and commit /
//               redirect outputs of the trap sequencer.
//               master : the sequencer (reads events, drives commit/redirect)
//               slave  : pipeline + CSR unit side
// Revision    : 1.0  initial release
// ============================================================================
interface trap_sequencer_if #(
    parameter int W = 64
);
    // Pipeline event inputs
    logic         i_exc_valid_f_d;
    logic [3:0]   i_exc_code_f_d;
    logic [W-1:0] i_exc_pc_f_d;
    logic         i_ecall_d;
    logic         i_mret_d;
    logic [W-1:0] i_pc_d;
    logic         i_exc_valid_e_m;
    logic [3:0]   i_exc_code_e_m;
    logic [W-1:0] i_exc_pc_e_m;
    logic [W-1:0] i_exc_addr_e_m;
    // CSR file values
    logic [1:0]   i_current_privilege;
    logic [W-1:0] i_mtvec;
    logic [W-1:0] i_mepc;
    // Commit record to the CSR unit
    logic [3:0]   o_exception_code_f_d_ff;
    logic [W-1:0] o_exception_pc_f_d_ff;
    logic [3:0]   o_exception_code_e_m_ff;
    logic [W-1:0] o_exception_pc_e_m_ff;
    logic [W-1:0] o_exception_addr_e_m_ff;
    logic         o_mret_e;
    // Pipeline control
    logic         o_flush;
    logic         o_stall_fetch;
    logic         o_pc_redirect;
    logic [W-1:0] o_pc_redirect_target;
    logic         o_busy;

    modport master (
        input  i_exc_valid_f_d, i_exc_code_f_d, i_exc_pc_f_d,
        input  i_ecall_d, i_mret_d, i_pc_d,
        input  i_exc_valid_e_m, i_exc_code_e_m, i_exc_pc_e_m, i_exc_addr_e_m,
        input  i_current_privilege, i_mtvec, i_mepc,
        output o_exception_code_f_d_ff, o_exception_pc_f_d_ff,
        output o_exception_code_e_m_ff, o_exception_pc_e_m_ff, o_exception_addr_e_m_ff,
        output o_mret_e, o_flush, o_stall_fetch,
        output o_pc_redirect, o_pc_redirect_target, o_busy
    );

    modport slave (
        output i_exc_valid_f_d, i_exc_code_f_d, i_exc_pc_f_d,
        output i_ecall_d, i_mret_d, i_pc_d,
        output i_exc_valid_e_m, i_exc_code_e_m, i_exc_pc_e_m, i_exc_addr_e_m,
        output i_current_privilege, i_mtvec, i_mepc,
        input  o_exception_code_f_d_ff, o_exception_pc_f_d_ff,
        input  o_exception_code_e_m_ff, o_exception_pc_e_m_ff, o_exception_addr_e_m_ff,
        input  o_mret_e, o_flush, o_stall_fetch,
        input  o_pc_redirect, o_pc_redirect_target, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/trap_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : trap_priority_select
// Description : Combinational arbiter over same-cycle trap events.
//               Priority: E/M exception > F/D exception > ecall > mret
//               (E/M holds the oldest instruction).
// Ports       : i_*           raw event inputs from the pipeline
//               o_ev_class    winning class (EV_NONE when nothing pending)
//               o_code/pc/addr record to latch for the winner
// Revision    : 1.0  initial release
// ============================================================================
module trap_priority_select
    import trap_pkg::*;
#(
    parameter int W = 64
) (
    input  wire logic         i_exc_valid_f_d,
    input  wire logic [3:0]   i_exc_code_f_d,
    input  wire logic [W-1:0] i_exc_pc_f_d,
    input  wire logic         i_ecall_d,
    input  wire logic         i_mret_d,
    input  wire logic [W-1:0] i_pc_d,
    input  wire logic         i_exc_valid_e_m,
    input  wire logic [3:0]   i_exc_code_e_m,
    input  wire logic [W-1:0] i_exc_pc_e_m,
    input  wire logic [W-1:0] i_exc_addr_e_m,
    input  wire logic [1:0]   i_current_privilege,
    output ev_class_t         o_ev_class,
    output logic [3:0]        o_code,
    output logic [W-1:0]      o_pc,
    output logic [W-1:0]      o_addr
);

    always_comb begin
        o_ev_class = EV_NONE;
        o_code     = EXC_NONE;
        o_pc       = '0;
        o_addr     = '0;
        if (i_exc_valid_e_m) begin
            o_ev_class = EV_EM;
            o_code     = i_exc_code_e_m;
            o_pc       = i_exc_pc_e_m;
            o_addr     = i_exc_addr_e_m;
        end else if (i_exc_valid_f_d) begin
            o_ev_class = EV_FD;
            o_code     = i_exc_code_f_d;
            o_pc       = i_exc_pc_f_d;
        end else if (i_ecall_d) begin
            o_ev_class = EV_FD;
            o_code     = ecall_cause(i_current_privilege);
            o_pc       = i_pc_d;
        end else if (i_mret_d) begin
            o_ev_class = EV_MRET;
            o_pc       = i_pc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Producer side of the CSR trap interface. Arbitrates pipeline
//               trap events, flushes the pipeline for FLUSH_CYCLES cycles,
//               presents one single-cycle commit record, then redirects the
//               PC to mtvec (trap) or mepc (mret).
// Ports       : i_clk     clock
//               i_rst     synchronous active-high reset (priority over i_clk_en)
//               i_clk_en  global stall; low freezes all state and outputs
//               bus       trap_sequencer_if.master (events in, commit/redirect out)
// Revision    : 1.0  initial release
// ============================================================================
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN         = XLEN_64B,
    parameter int FLUSH_CYCLES = 2           // legal range 1..15
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    input  wire logic        i_clk_en,
    trap_sequencer_if.master bus
);

    localparam int           W            = 1 << (XLEN + 4);
    localparam logic [3:0]   C_CNT_INIT   = 4'(FLUSH_CYCLES - 1);
    localparam logic [W-1:0] C_ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};

    // Arbiter result
    ev_class_t    sel_class_w;
    logic [3:0]   sel_code_w;
    logic [W-1:0] sel_pc_w;
    logic [W-1:0] sel_addr_w;

    // State and latched trap record
    trap_state_t  state_q, state_d;
    logic [3:0]   cnt_q,   cnt_d;
    ev_class_t    class_q, class_d;
    logic [3:0]   code_q,  code_d;
    logic [W-1:0] pc_q,    pc_d;
    logic [W-1:0] addr_q,  addr_d;

    trap_priority_select #(.W(W)) u_prio (
        .i_exc_valid_f_d     (bus.i_exc_valid_f_d),
        .i_exc_code_f_d      (bus.i_exc_code_f_d),
        .i_exc_pc_f_d        (bus.i_exc_pc_f_d),
        .i_ecall_d           (bus.i_ecall_d),
        .i_mret_d            (bus.i_mret_d),
        .i_pc_d              (bus.i_pc_d),
        .i_exc_valid_e_m     (bus.i_exc_valid_e_m),
        .i_exc_code_e_m      (bus.i_exc_code_e_m),
        .i_exc_pc_e_m        (bus.i_exc_pc_e_m),
        .i_exc_addr_e_m      (bus.i_exc_addr_e_m),
        .i_current_privilege (bus.i_current_privilege),
        .o_ev_class          (sel_class_w),
        .o_code              (sel_code_w),
        .o_pc                (sel_pc_w),
        .o_addr              (sel_addr_w)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            class_q <= EV_NONE;
            code_q  <= EXC_NONE;
            pc_q    <= '0;
            addr_q  <= '0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            class_q <= class_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    // Next state: events are only accepted in IDLE; anything raised while a
    // sequence is active belongs to younger instructions that get flushed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        class_d = class_q;
        code_d  = code_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_class_w != EV_NONE) begin
                    state_d = ST_FLUSH;
                    cnt_d   = C_CNT_INIT;
                    class_d = sel_class_w;
                    code_d  = sel_code_w;
                    pc_d    = sel_pc_w;
                    addr_d  = sel_addr_w;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state, so no input-to-commit path exists.
    // The redirect target reads the CSR file in REDIRECT, i.e. after any CSR
    // update performed in response to the COMMIT record.
    always_comb begin
        bus.o_exception_code_f_d_ff = EXC_NONE;
        bus.o_exception_pc_f_d_ff   = '0;
        bus.o_exception_code_e_m_ff = EXC_NONE;
        bus.o_exception_pc_e_m_ff   = '0;
        bus.o_exception_addr_e_m_ff = '0;
        bus.o_mret_e                = 1'b0;
        bus.o_flush                 = 1'b0;
        bus.o_stall_fetch           = 1'b0;
        bus.o_pc_redirect           = 1'b0;
        bus.o_pc_redirect_target    = '0;
        bus.o_busy                  = (state_q != ST_IDLE);
        case (state_q)
            ST_FLUSH: begin
                bus.o_flush       = 1'b1;
                bus.o_stall_fetch = 1'b1;
            end
            ST_COMMIT: begin
                bus.o_stall_fetch = 1'b1;
                case (class_q)
                    EV_FD: begin
                        bus.o_exception_code_f_d_ff = code_q;
                        bus.o_exception_pc_f_d_ff   = pc_q;
                    end
                    EV_EM: begin
                        bus.o_exception_code_e_m_ff = code_q;
                        bus.o_exception_pc_e_m_ff   = pc_q;
                        bus.o_exception_addr_e_m_ff = addr_q;
                    end
                    EV_MRET: bus.o_mret_e = 1'b1;
                    default: ;
                endcase
            end
            ST_REDIRECT: begin
                bus.o_pc_redirect        = 1'b1;
                bus.o_pc_redirect_target = (class_q == EV_MRET) ? bus.i_mepc
                                                                : (bus.i_mtvec & C_ALIGN_MASK);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Directed self-checking bench for trap_sequencer.
//               Inputs change on the falling edge, outputs are checked on
//               the falling edge before the next change.
// Revision    : 1.0  initial release
// ============================================================================
module tb_trap_sequencer;
    import trap_pkg::*;

    logic clk;
    logic rst;
    logic clk_en;
    int   vec_cnt;
    int   err_cnt;

    trap_sequencer_if #(.W(64)) bus ();

    trap_sequencer #(.XLEN(XLEN_64B), .FLUSH_CYCLES(2)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_events();
        bus.i_exc_valid_f_d = 1'b0;
        bus.i_exc_valid_e_m = 1'b0;
        bus.i_ecall_d       = 1'b0;
        bus.i_mret_d        = 1'b0;
    endtask

    // Full commit-record check; mret flag, flush and redirect included
    task automatic chk_commit(input string tag,
                              input logic [3:0] fd_code, input logic [63:0] fd_pc,
                              input logic [3:0] em_code, input logic [63:0] em_pc,
                              input logic [63:0] em_addr, input logic mret);
        chk({tag, ".fd_code"}, 64'(bus.o_exception_code_f_d_ff), 64'(fd_code));
        chk({tag, ".fd_pc"},   bus.o_exception_pc_f_d_ff,        fd_pc);
        chk({tag, ".em_code"}, 64'(bus.o_exception_code_e_m_ff), 64'(em_code));
        chk({tag, ".em_pc"},   bus.o_exception_pc_e_m_ff,        em_pc);
        chk({tag, ".em_addr"}, bus.o_exception_addr_e_m_ff,      em_addr);
        chk({tag, ".mret"},    64'(bus.o_mret_e),                64'(mret));
        chk({tag, ".flush"},   64'(bus.o_flush),                 64'd0);
        chk({tag, ".stall"},   64'(bus.o_stall_fetch),           64'd1);
        chk({tag, ".redir"},   64'(bus.o_pc_redirect),           64'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},    64'(bus.o_busy),                  64'd0);
        chk({tag, ".flush"},   64'(bus.o_flush),                 64'd0);
        chk({tag, ".stall"},   64'(bus.o_stall_fetch),           64'd0);
        chk({tag, ".redir"},   64'(bus.o_pc_redirect),           64'd0);
        chk({tag, ".target"},  bus.o_pc_redirect_target,         64'd0);
        chk({tag, ".mret"},    64'(bus.o_mret_e),                64'd0);
        chk({tag, ".fd_code"}, 64'(bus.o_exception_code_f_d_ff), 64'hF);
        chk({tag, ".em_code"}, 64'(bus.o_exception_code_e_m_ff), 64'hF);
        chk({tag, ".fd_pc"},   bus.o_exception_pc_f_d_ff,        64'd0);
        chk({tag, ".em_pc"},   bus.o_exception_pc_e_m_ff,        64'd0);
        chk({tag, ".em_addr"}, bus.o_exception_addr_e_m_ff,      64'd0);
    endtask

    task automatic chk_flush(input string tag);
        chk({tag, ".busy"},    64'(bus.o_busy),                  64'd1);
        chk({tag, ".flush"},   64'(bus.o_flush),                 64'd1);
        chk({tag, ".stall"},   64'(bus.o_stall_fetch),           64'd1);
        chk({tag, ".redir"},   64'(bus.o_pc_redirect),           64'd0);
        chk({tag, ".fd_code"}, 64'(bus.o_exception_code_f_d_ff), 64'hF);
        chk({tag, ".em_code"}, 64'(bus.o_exception_code_e_m_ff), 64'hF);
        chk({tag, ".mret"},    64'(bus.o_mret_e),                64'd0);
    endtask

    task automatic chk_redirect(input string tag, input logic [63:0] target);
        chk({tag, ".redir"},   64'(bus.o_pc_redirect),           64'd1);
        chk({tag, ".target"},  bus.o_pc_redirect_target,         target);
        chk({tag, ".flush"},   64'(bus.o_flush),                 64'd0);
        chk({tag, ".fd_code"}, 64'(bus.o_exception_code_f_d_ff), 64'hF);
        chk({tag, ".em_code"}, 64'(bus.o_exception_code_e_m_ff), 64'hF);
        chk({tag, ".mret"},    64'(bus.o_mret_e),                64'd0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        clk_en  = 1'b1;
        clear_events();
        bus.i_exc_code_f_d      = 4'd0;
        bus.i_exc_pc_f_d        = 64'd0;
        bus.i_pc_d              = 64'd0;
        bus.i_exc_code_e_m      = 4'd0;
        bus.i_exc_pc_e_m        = 64'd0;
        bus.i_exc_addr_e_m      = 64'd0;
        bus.i_current_privilege = PRIV_M;
        bus.i_mtvec             = 64'h8000_0001;
        bus.i_mepc              = 64'd0;

        // ---- reset state
        step(); step();
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("post_reset");

        // ---- 1: E/M load misalign
        bus.i_exc_valid_e_m = 1'b1;
        bus.i_exc_code_e_m  = 4'd4;
        bus.i_exc_pc_e_m    = 64'h100;
        bus.i_exc_addr_e_m  = 64'h203;
        step();
        clear_events();
        chk_flush("t1.flush0");
        step();
        chk_flush("t1.flush1");
        step();
        chk_commit("t1.commit", 4'hF, 64'd0, 4'd4, 64'h100, 64'h203, 1'b0);
        step();
        chk_redirect("t1.redir", 64'h8000_0000);
        step();
        chk_idle("t1.done");

        // ---- 2: simultaneous F/D illegal and E/M store fault
        bus.i_exc_valid_f_d = 1'b1;
        bus.i_exc_code_f_d  = 4'd2;
        bus.i_exc_pc_f_d    = 64'h200;
        bus.i_exc_valid_e_m = 1'b1;
        bus.i_exc_code_e_m  = 4'd7;
        bus.i_exc_pc_e_m    = 64'h300;
        bus.i_exc_addr_e_m  = 64'h400;
        step();
        bus.i_exc_valid_e_m = 1'b0;
        // F/D stays raised during the flush and must be ignored
        chk_flush("t2.flush0");
        step();
        chk_flush("t2.flush1");
        bus.i_exc_valid_f_d = 1'b0;
        step();
        chk_commit("t2.commit", 4'hF, 64'd0, 4'd7, 64'h300, 64'h400, 1'b0);
        step();
        chk_redirect("t2.redir", 64'h8000_0000);
        step();
        chk_idle("t2.done");

        // ---- 3: ecall from U, then from M
        bus.i_ecall_d           = 1'b1;
        bus.i_pc_d              = 64'h40;
        bus.i_current_privilege = PRIV_U;
        step();
        clear_events();
        step(); step();
        chk_commit("t3u.commit", 4'd8, 64'h40, 4'hF, 64'd0, 64'd0, 1'b0);
        step();
        chk_redirect("t3u.redir", 64'h8000_0000);
        step();
        bus.i_ecall_d           = 1'b1;
        bus.i_current_privilege = PRIV_M;
        step();
        clear_events();
        step(); step();
        chk_commit("t3m.commit", 4'd11, 64'h40, 4'hF, 64'd0, 64'd0, 1'b0);
        step(); step();
        chk_idle("t3.done");

        // ---- 4: mret
        bus.i_mret_d = 1'b1;
        bus.i_mepc   = 64'h1234;
        bus.i_pc_d   = 64'h88;
        step();
        clear_events();
        chk_flush("t4.flush0");
        step(); step();
        chk_commit("t4.commit", 4'hF, 64'd0, 4'hF, 64'd0, 64'd0, 1'b1);
        step();
        chk_redirect("t4.redir", 64'h1234);
        step();
        chk_idle("t4.done");

        // ---- 5: clock enable low for 3 cycles mid-FLUSH
        bus.i_exc_valid_e_m = 1'b1;
        bus.i_exc_code_e_m  = 4'd5;
        bus.i_exc_pc_e_m    = 64'h500;
        bus.i_exc_addr_e_m  = 64'h600;
        step();
        clear_events();
        chk_flush("t5.flush0");
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_flush($sformatf("t5.frozen%0d", i));
        end
        clk_en = 1'b1;
        step();
        chk_flush("t5.flush1");
        step();
        chk_commit("t5.commit", 4'hF, 64'd0, 4'd5, 64'h500, 64'h600, 1'b0);
        step();
        chk_redirect("t5.redir", 64'h8000_0000);
        step();
        chk_idle("t5.done");

        // ---- 6: reset during COMMIT
        bus.i_exc_valid_e_m = 1'b1;
        bus.i_exc_code_e_m  = 4'd6;
        bus.i_exc_pc_e_m    = 64'h700;
        bus.i_exc_addr_e_m  = 64'h701;
        step();
        clear_events();
        step(); step();
        chk_commit("t6.commit", 4'hF, 64'd0, 4'd6, 64'h700, 64'h701, 1'b0);
        rst = 1'b1;
        step();
        chk_idle("t6.reset");
        rst = 1'b0;
        step();
        chk_idle("t6.after");
        step();
        chk_idle("t6.after2");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
